// File: rtl/idli_pkg.sv
// Shared types for the idli core: predicate register names and compare unit encodings.
package idli_pkg;

    typedef enum logic [1:0] {
        P0 = 2'd0,
        P1 = 2'd1,
        P2 = 2'd2,
        P3 = 2'd3
    } preg_t;

    typedef enum logic [2:0] {
        CMP_EQ   = 3'd0,
        CMP_NE   = 3'd1,
        CMP_LT   = 3'd2,
        CMP_LTU  = 3'd3,
        CMP_GE   = 3'd4,
        CMP_GEU  = 3'd5,
        CMP_TST  = 3'd6,
        CMP_NTST = 3'd7
    } cmp_op_t;

    localparam int CMP_NIBBLES = 4;

    typedef logic [3:0] nibble_t;

endpackage

// File: rtl/idli_cmp_m.sv
// Nibble-serial 16-bit compare unit; writes one boolean result to the predicate file
// in the cycle after the last operand nibble.
module idli_cmp_m
    import idli_pkg::*;
(
    input  logic    i_cmp_gck,
    input  logic    i_cmp_rst,
    input  logic    i_cmp_start,
    input  cmp_op_t i_cmp_op,
    input  preg_t   i_cmp_dst,
    input  nibble_t i_cmp_a,
    input  nibble_t i_cmp_b,
    output logic    o_cmp_busy,
    output preg_t   o_pred_wr,
    output logic    o_pred_wr_en,
    output logic    o_pred_wr_data
);

    logic [1:0] cnt;
    logic       busy;
    cmp_op_t    op_q;
    preg_t      dst_q;
    logic       carry_q;
    logic       eq_q;
    logic       tst_q;

    logic       accept;
    logic       last;
    logic       cin;
    nibble_t    nb;
    logic [4:0] sum_full;
    nibble_t    sum;
    logic       cout;
    logic       eq_n;
    logic       tst_n;
    logic       flag_n;
    logic       flag_v;
    logic       result;

    // Start is only honoured between compares; busy covers nibbles 1..3.
    assign accept = i_cmp_start && !busy;
    assign last   = busy && (cnt == 2'd3);

    // A - B computed as A + ~B + 1, carry chained through the nibbles.
    assign cin      = accept ? 1'b1 : carry_q;
    assign nb       = ~i_cmp_b;
    assign sum_full = {1'b0, i_cmp_a} + {1'b0, nb} + {4'b0000, cin};
    assign sum      = sum_full[3:0];
    assign cout     = sum_full[4];
    assign eq_n     = (accept ? 1'b1 : eq_q) & (i_cmp_a == i_cmp_b);
    assign tst_n    = (accept ? 1'b0 : tst_q) | (|(i_cmp_a & i_cmp_b));
    assign flag_n   = sum[3];
    assign flag_v   = (i_cmp_a[3] == nb[3]) && (sum[3] != i_cmp_a[3]);

    always_comb begin
        result = 1'b0;
        case (op_q)
            CMP_EQ:   result = eq_n;
            CMP_NE:   result = !eq_n;
            CMP_LT:   result = flag_n ^ flag_v;
            CMP_LTU:  result = !cout;
            CMP_GE:   result = !(flag_n ^ flag_v);
            CMP_GEU:  result = cout;
            CMP_TST:  result = tst_n;
            CMP_NTST: result = !tst_n;
            default:  result = 1'b0;
        endcase
    end

    always_ff @(posedge i_cmp_gck or posedge i_cmp_rst) begin
        if (i_cmp_rst) begin
            cnt            <= 2'd0;
            busy           <= 1'b0;
            op_q           <= CMP_EQ;
            dst_q          <= P0;
            carry_q        <= 1'b0;
            eq_q           <= 1'b0;
            tst_q          <= 1'b0;
            o_pred_wr_en   <= 1'b0;
            o_pred_wr      <= P0;
            o_pred_wr_data <= 1'b0;
        end else begin
            o_pred_wr_en <= 1'b0;
            if (accept) begin
                cnt     <= 2'd1;
                busy    <= 1'b1;
                op_q    <= i_cmp_op;
                dst_q   <= i_cmp_dst;
                carry_q <= cout;
                eq_q    <= eq_n;
                tst_q   <= tst_n;
            end else if (busy) begin
                carry_q <= cout;
                eq_q    <= eq_n;
                tst_q   <= tst_n;
                if (last) begin
                    cnt  <= 2'd0;
                    busy <= 1'b0;
                    // P3 is hardwired true, so a write to it is dropped.
                    if (dst_q != P3) begin
                        o_pred_wr_en   <= 1'b1;
                        o_pred_wr      <= dst_q;
                        o_pred_wr_data <= result;
                    end
                end else begin
                    cnt <= cnt + 2'd1;
                end
            end
        end
    end

    assign o_cmp_busy = busy;

endmodule

// File: doc/idli_cmp_m.md
Name: idli_cmp_m

Overview:
Nibble-serial comparison unit that produces predicate results for the predicate register file's single write port. Two 16-bit operands arrive LSB nibble first over 4 consecutive cycles. The unit accumulates subtract carry, equality and AND-test state, and writes the boolean result to the destination predicate in the cycle after the last nibble. It sits directly upstream of the predicate file, and its write outputs connect 1:1 to that file's write port.

Parameters:
None. Operand width is fixed at 16 bits, 4 nibbles of 4 bits each, from the shared package.

Ports:
i_cmp_gck       in   1  clock
i_cmp_rst       in   1  reset; asynchronous, active-high
i_cmp_start     in   1  nibble 0 of a new compare is on i_cmp_a/b this cycle; latches op and dst
i_cmp_op        in   3  cmp_op_t, sampled only when start is accepted
i_cmp_dst       in   2  preg_t destination, sampled only when start is accepted
i_cmp_a         in   4  operand A nibble, LSB nibble first
i_cmp_b         in   4  operand B nibble, LSB nibble first
o_cmp_busy      out  1  compare in flight (nibbles 1..3 expected)
o_pred_wr       out  2  preg_t destination, to the predicate file
o_pred_wr_en    out  1  predicate write enable, to the predicate file
o_pred_wr_data  out  1  predicate result, to the predicate file

Behaviour:
- Reset (async assert): counter = 0, busy = 0, o_pred_wr_en = 0, o_pred_wr = 0, o_pred_wr_data = 0, internal flags cleared. Reset mid-compare aborts the compare; no write is ever issued for it.
- Cycle numbering is relative to the accepted start:
  - c0: accepted start, nibble 0 consumed.
  - c1..c3: nibbles 1..3 consumed; o_cmp_busy = 1.
  - c4: o_pred_wr_en = 1 for exactly one cycle (registered output).
- Start acceptance: i_cmp_start is accepted only when o_cmp_busy = 0. Start during c1..c3 is ignored; the in-flight compare is unaffected.
- Start in c4 is legal and accepted, giving a sustained throughput of one compare per 4 cycles.
- Arithmetic: A + ~B + 1, nibble-serial.
  - carry_in for nibble 0 = 1; carry out is registered into the next nibble.
  - eq flag = AND over all nibbles of (a == b).
  - tst flag = OR over all nibbles of (a & b) != 0.
  - At nibble 3, capture: N = sum bit 15, V = signed overflow of bit 15, C = final carry.
- Result by op:
  - EQ(0) = eq
  - NE(1) = !eq
  - LT(2) = N ^ V
  - LTU(3) = !C
  - GE(4) = !(N ^ V)
  - GEU(5) = C
  - TST(6) = tst
  - NTST(7) = !tst
- Destination P3 is hardwired true, so dst == P3 suppresses o_pred_wr_en. The compare still runs and busy behaves normally.
- o_pred_wr and o_pred_wr_data hold their last values when o_pred_wr_en = 0. Consumers must ignore them then.
- Counter wraps 3 -> 0 at the end of c3, and busy drops in the same edge.
- The predicate file bypasses same-cycle writes, so a reader of dst in c4 sees the new value with no extra stall.

Decomposition:
- idli_pkg gains:
  - cmp_op_t: 3-bit enum with the 8 ops listed above.
  - CMP_NIBBLES = 4.
  - nibble_t: 4 bits.
- preg_t is reused unchanged.
- No sub-module. The per-nibble adder/flag logic is ~15 lines and stays inline. The counter, flag registers and output register live in one always_ff with async reset.

Test Plan:
- EQ, A=0x1234, B=0x1234, dst=P0 → c4: wr_en=1, wr=P0, data=1. Repeat with B=0x1235 → data=0.
- LT/LTU, A=0x8000, B=0x0001 → LT=1, LTU=0. A=0x0001, B=0x8000 → LT=0, LTU=1. A=0x7FFF, B=0x8000 → LT=0, GE=1 (overflow case).
- TST, A=0x00F0, B=0x0010 → TST=1. A=0xF0F0, B=0x0F0F → TST=0, NTST=1.
- Start pulses in c0, c2 (ignored) and c4 → exactly two writes, at c4 and c8, each matching its own operands and op.
- dst=P3 with EQ on equal operands → busy c1..c3, no wr_en in c4.
- Assert i_cmp_rst in c2 of a compare → all outputs 0 immediately, no wr_en afterwards. A new start after reset release completes normally.
